// File: rtl/paicore_gen_pkg.sv
// ----------------------------------------------------------------------------
// paicore_gen_pkg
// Shared types and constants for the PAICORE frame generator:
//   - state_e            : frame generator FSM states
//   - MODE_*             : pattern mode encodings carried on i_mode
//   - DEFAULT_LFSR_TAPS  : Galois LFSR feedback mask used when none is given
// ----------------------------------------------------------------------------
package paicore_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SEND    = 2'd1,
        ST_WAIT_TX = 2'd2
    } state_e;

    localparam logic [1:0] MODE_COUNTER     = 2'd0;
    localparam logic [1:0] MODE_LFSR        = 2'd1;
    localparam logic [1:0] MODE_FIXED       = 2'd2;
    localparam logic [1:0] MODE_COUNTER_ALT = 2'd3;

    localparam logic [63:0] DEFAULT_LFSR_TAPS = 64'hD800_0000_0000_0000;

endpackage : paicore_gen_pkg

// File: rtl/paicore_pattern_src.sv
// ----------------------------------------------------------------------------
// paicore_pattern_src
// Holds the word currently presented on the stream and steps it to the next
// pattern value. The mode is captured on load so a frame keeps one pattern.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   i_load      : capture mode and seed; word becomes the frame's word 0
//   i_advance   : step to the next word of the pattern
//   i_mode      : pattern mode (counter / LFSR / fixed / counter)
//   i_seed      : first word, or LFSR seed
//   o_word      : current pattern word
// ----------------------------------------------------------------------------
module paicore_pattern_src
    import paicore_gen_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = 64,
    parameter logic [DATA_WIDTH-1:0] TAPS       = DEFAULT_LFSR_TAPS[DATA_WIDTH-1:0]
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_load,
    input  logic                  i_advance,
    input  logic [1:0]            i_mode,
    input  logic [DATA_WIDTH-1:0] i_seed,
    output logic [DATA_WIDTH-1:0] o_word
);

    logic [1:0]            mode_q, mode_d;
    logic [DATA_WIDTH-1:0] word_q, word_d;

    // An all-zero LFSR state would lock up, so a zero seed is replaced by 1.
    always_comb begin
        mode_d = mode_q;
        word_d = word_q;
        if (i_load) begin
            mode_d = i_mode;
            if ((i_mode == MODE_LFSR) && (i_seed == '0)) begin
                word_d = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
            end else begin
                word_d = i_seed;
            end
        end else if (i_advance) begin
            case (mode_q)
                MODE_LFSR:  word_d = (word_q >> 1) ^ (word_q[0] ? TAPS : '0);
                MODE_FIXED: word_d = word_q;
                default:    word_d = word_q + {{(DATA_WIDTH-1){1'b0}}, 1'b1};
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q <= MODE_COUNTER;
            word_q <= '0;
        end else begin
            mode_q <= mode_d;
            word_q <= word_d;
        end
    end

    assign o_word = word_q;

endmodule : paicore_pattern_src

// File: rtl/paicore_frame_gen.sv
// ----------------------------------------------------------------------------
// paicore_frame_gen
// Stimulus stage for the PAICORE loop-back path. On an accepted i_start it
// emits one AXI-Stream frame of i_send_len words, then (optionally) waits for
// the sender's tx-done pulse with a timeout and reports done/timeout.
// Ports:
//   clk, rst           : clock, asynchronous active-high reset
//   i_start            : start pulse, honoured only when idle
//   i_abort            : end the current frame early
//   i_mode             : 0/3 counter, 1 LFSR, 2 fixed
//   i_send_len         : words per frame (sampled at start)
//   i_seed             : first word / LFSR seed (sampled at start)
//   i_tx_done          : tx-done pulse from the send stage
//   m_axis_*           : AXI-Stream master (tdata, tlast, tvalid, tready)
//   o_busy             : frame in progress (sending or waiting)
//   o_done             : one-cycle pulse when a frame returns to idle
//   o_timeout          : sticky timeout flag, cleared by the next start
//   o_word_cnt         : beats handshaked in the current/last frame
// ----------------------------------------------------------------------------
module paicore_frame_gen
    import paicore_gen_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 64,
    parameter logic [63:0] LFSR_TAPS   = DEFAULT_LFSR_TAPS,
    parameter bit          WAIT_TX     = 1'b1,
    parameter logic [31:0] TIMEOUT_CYC = 32'd1_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic                  i_abort,
    input  logic [1:0]            i_mode,
    input  logic [31:0]           i_send_len,
    input  logic [DATA_WIDTH-1:0] i_seed,
    input  logic                  i_tx_done,
    input  logic                  m_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tvalid,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_timeout,
    output logic [31:0]           o_word_cnt
);

    state_e      state_q, state_d;
    logic        tvalid_q, tvalid_d;
    logic        tlast_q, tlast_d;
    logic [31:0] word_cnt_q, word_cnt_d;
    logic [31:0] len_q, len_d;
    logic [31:0] wait_cnt_q, wait_cnt_d;
    logic        tx_seen_q, tx_seen_d;
    logic        done_q, done_d;
    logic        timeout_q, timeout_d;
    logic        pat_load, pat_advance;
    logic        handshake;

    assign handshake = tvalid_q & m_axis_tready;

    // Pattern register doubles as the tdata holding register; it only moves
    // on a handshake, so data stays stable while the sink stalls.
    paicore_pattern_src #(
        .DATA_WIDTH (DATA_WIDTH),
        .TAPS       (LFSR_TAPS[DATA_WIDTH-1:0])
    ) u_pattern (
        .clk       (clk),
        .rst       (rst),
        .i_load    (pat_load),
        .i_advance (pat_advance),
        .i_mode    (i_mode),
        .i_seed    (i_seed),
        .o_word    (m_axis_tdata)
    );

    // tlast is registered alongside tvalid. It is precomputed for the next
    // beat on each handshake (next index = word_cnt+1 is last when
    // word_cnt+2 == len). An abort forces it onto whichever beat is presented
    // next: the held beat if stalled, otherwise the following one.
    // A tx-done arriving while still sending is remembered so WAIT_TX can
    // finish straight away.
    always_comb begin
        state_d     = state_q;
        tvalid_d    = tvalid_q;
        tlast_d     = tlast_q;
        word_cnt_d  = word_cnt_q;
        len_d       = len_q;
        wait_cnt_d  = wait_cnt_q;
        tx_seen_d   = tx_seen_q;
        done_d      = 1'b0;
        timeout_d   = timeout_q;
        pat_load    = 1'b0;
        pat_advance = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    timeout_d  = 1'b0;
                    word_cnt_d = '0;
                    wait_cnt_d = '0;
                    tx_seen_d  = 1'b0;
                    len_d      = i_send_len;
                    if (i_send_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d  = ST_SEND;
                        tvalid_d = 1'b1;
                        tlast_d  = (i_send_len == 32'd1);
                        pat_load = 1'b1;
                    end
                end
            end

            ST_SEND: begin
                if (i_tx_done) begin
                    tx_seen_d = 1'b1;
                end
                if (handshake) begin
                    word_cnt_d = word_cnt_q + 32'd1;
                    if (tlast_q) begin
                        tvalid_d   = 1'b0;
                        tlast_d    = 1'b0;
                        wait_cnt_d = '0;
                        if (WAIT_TX) begin
                            state_d = ST_WAIT_TX;
                        end else begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        pat_advance = 1'b1;
                        tlast_d     = i_abort || ((word_cnt_q + 32'd2) == len_q);
                    end
                end else if (i_abort) begin
                    tlast_d = 1'b1;
                end
            end

            ST_WAIT_TX: begin
                if (i_tx_done || tx_seen_q || i_abort) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else if ((wait_cnt_q + 32'd1) >= TIMEOUT_CYC) begin
                    state_d   = ST_IDLE;
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 32'd1;
                end
            end

            default: begin
                state_d  = ST_IDLE;
                tvalid_d = 1'b0;
                tlast_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
            word_cnt_q <= '0;
            len_q      <= '0;
            wait_cnt_q <= '0;
            tx_seen_q  <= 1'b0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            tvalid_q   <= tvalid_d;
            tlast_q    <= tlast_d;
            word_cnt_q <= word_cnt_d;
            len_q      <= len_d;
            wait_cnt_q <= wait_cnt_d;
            tx_seen_q  <= tx_seen_d;
            done_q     <= done_d;
            timeout_q  <= timeout_d;
        end
    end

    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign o_busy        = (state_q == ST_SEND) || (state_q == ST_WAIT_TX);
    assign o_done        = done_q;
    assign o_timeout     = timeout_q;
    assign o_word_cnt    = word_cnt_q;

endmodule : paicore_frame_gen
